// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: oldest-ready issue,
// CDB operand snoop with dispatch bypass, flush and occupancy.
module reservation_station #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int OP_W    = 5,
  parameter int ENTRIES = 4,
  parameter int CNT_W   = $clog2(ENTRIES+1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              disp_valid_i,
  output logic              disp_ready_o,
  input  logic [OP_W-1:0]   disp_op_i,
  input  logic [TAG_W-1:0]  disp_dest_i,
  input  logic [DATA_W-1:0] disp_vj_i,
  input  logic [DATA_W-1:0] disp_vk_i,
  input  logic [TAG_W-1:0]  disp_qj_i,
  input  logic [TAG_W-1:0]  disp_qk_i,
  input  logic              disp_wj_i,
  input  logic              disp_wk_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              iss_valid_o,
  input  logic              iss_ready_i,
  output logic [OP_W-1:0]   iss_op_o,
  output logic [TAG_W-1:0]  iss_dest_o,
  output logic [DATA_W-1:0] iss_vj_o,
  output logic [DATA_W-1:0] iss_vk_o,
  output logic [CNT_W-1:0]  occupancy_o
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              wj;
    logic              wk;
  } ent_t;

  ent_t             ent_q [ENTRIES];
  ent_t             ent_d [ENTRIES];
  ent_t             snp   [ENTRIES];
  ent_t             nw;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr;
  logic [ENTRIES-1:0] rdy;
  logic [IDX_W-1:0] sel;
  logic             fire_iss;
  logic             fire_disp;

  assign disp_ready_o = (cnt_q < CNT_W'(ENTRIES)) && !flush_i;
  assign occupancy_o  = cnt_q;
  assign iss_valid_o  = |rdy;
  assign fire_iss     = iss_valid_o && iss_ready_i;
  assign fire_disp    = disp_valid_i && disp_ready_o;
  assign wr           = cnt_q - CNT_W'(fire_iss);

  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rdy[i] = (CNT_W'(i) < cnt_q) &&
               !ent_q[i].wj && !ent_q[i].wk;
    end
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (rdy[i]) sel = IDX_W'(i);
    end
  end

  always_comb begin
    iss_op_o   = '0;
    iss_dest_o = '0;
    iss_vj_o   = '0;
    iss_vk_o   = '0;
    if (iss_valid_o) begin
      iss_op_o   = ent_q[sel].op;
      iss_dest_o = ent_q[sel].dest;
      iss_vj_o   = ent_q[sel].vj;
      iss_vk_o   = ent_q[sel].vk;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      snp[i] = ent_q[i];
      if (cdb_valid_i && ent_q[i].wj &&
          ent_q[i].qj == cdb_tag_i) begin
        snp[i].vj = cdb_data_i;
        snp[i].wj = 1'b0;
      end
      if (cdb_valid_i && ent_q[i].wk &&
          ent_q[i].qk == cdb_tag_i) begin
        snp[i].vk = cdb_data_i;
        snp[i].wk = 1'b0;
      end
    end
  end

  always_comb begin
    nw.op   = disp_op_i;
    nw.dest = disp_dest_i;
    nw.qj   = disp_qj_i;
    nw.qk   = disp_qk_i;
    nw.vj   = disp_vj_i;
    nw.vk   = disp_vk_i;
    nw.wj   = disp_wj_i;
    nw.wk   = disp_wk_i;
    if (cdb_valid_i && disp_wj_i && disp_qj_i == cdb_tag_i) begin
      nw.vj = cdb_data_i;
      nw.wj = 1'b0;
    end
    if (cdb_valid_i && disp_wk_i && disp_qk_i == cdb_tag_i) begin
      nw.vk = cdb_data_i;
      nw.wk = 1'b0;
    end
  end

  // Shift down above the issued slot, then drop the new op at the tail
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) ent_d[i] = snp[i];
    if (fire_iss) begin
      for (int i = 0; i < ENTRIES-1; i++) begin
        if (i >= int'(sel)) ent_d[i] = snp[i+1];
      end
      ent_d[ENTRIES-1] = '0;
    end
    if (fire_disp) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (CNT_W'(i) == wr) ent_d[i] = nw;
      end
    end
    cnt_d = cnt_q + CNT_W'(fire_disp) - CNT_W'(fire_iss);
    if (flush_i) begin
      cnt_d = '0;
      for (int i = 0; i < ENTRIES; i++) ent_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue order, CDB wake,
// bypass, full boundary, flush and asynchronous reset.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_op;
  logic [2:0]  disp_dest;
  logic [15:0] disp_vj, disp_vk;
  logic [2:0]  disp_qj, disp_qk;
  logic        disp_wj, disp_wk;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_op;
  logic [2:0]  iss_dest;
  logic [15:0] iss_vj, iss_vk;
  logic [2:0]  occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .disp_valid_i (disp_valid),
    .disp_ready_o (disp_ready),
    .disp_op_i    (disp_op),
    .disp_dest_i  (disp_dest),
    .disp_vj_i    (disp_vj),
    .disp_vk_i    (disp_vk),
    .disp_qj_i    (disp_qj),
    .disp_qk_i    (disp_qk),
    .disp_wj_i    (disp_wj),
    .disp_wk_i    (disp_wk),
    .cdb_valid_i  (cdb_valid),
    .cdb_tag_i    (cdb_tag),
    .cdb_data_i   (cdb_data),
    .iss_valid_o  (iss_valid),
    .iss_ready_i  (iss_ready),
    .iss_op_o     (iss_op),
    .iss_dest_o   (iss_dest),
    .iss_vj_o     (iss_vj),
    .iss_vk_o     (iss_vk),
    .occupancy_o  (occ)
  );

  task automatic drive_disp(input logic [4:0] op,
                            input logic [2:0] dest,
                            input logic [15:0] vj,
                            input logic [15:0] vk,
                            input logic wj,
                            input logic [2:0] qj);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_dest  = dest;
    disp_vj    = vj;
    disp_vk    = vk;
    disp_wj    = wj;
    disp_qj    = qj;
    disp_wk    = 1'b0;
    disp_qk    = 3'd0;
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_op    = '0;
    disp_dest  = '0;
    disp_vj    = '0;
    disp_vk    = '0;
    disp_qj    = '0;
    disp_qk    = '0;
    disp_wj    = 1'b0;
    disp_wk    = 1'b0;
    cdb_valid  = 1'b0;
    cdb_tag    = '0;
    cdb_data   = '0;
    iss_ready  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    if (occ !== 3'd0) begin
      bad++; $display("FAIL rst_occ got=%0d exp=0", occ);
    end
    total++;
    if (iss_valid !== 1'b0) begin
      bad++; $display("FAIL rst_iss_valid got=%b exp=0", iss_valid);
    end
    total++;
    if ({iss_op, iss_dest, iss_vj, iss_vk} !== 40'd0) begin
      bad++; $display("FAIL rst_iss_fields got=%h exp=0",
                      {iss_op, iss_dest, iss_vj, iss_vk});
    end
    total++;
    if (disp_ready !== 1'b1) begin
      bad++; $display("FAIL rst_disp_ready got=%b exp=1", disp_ready);
    end
    total++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive_disp(5'd2, 3'd3, 16'h1000, 16'h0005, 1'b0, 3'd0);
    iss_ready = 1'b1;
    @(negedge clk);
    if (iss_valid !== 1'b1 || iss_vj !== 16'h1000 ||
        iss_vk !== 16'h0005 || iss_op !== 5'd2 ||
        iss_dest !== 3'd3) begin
      bad++; $display("FAIL basic_issue got v=%b op=%0d d=%0d vj=%h vk=%h exp v=1 op=2 d=3 vj=1000 vk=0005",
                      iss_valid, iss_op, iss_dest, iss_vj, iss_vk);
    end
    total++;
    if (occ !== 3'd1) begin
      bad++; $display("FAIL basic_occ1 got=%0d exp=1", occ);
    end
    total++;
    disp_valid = 1'b0;
    @(negedge clk);
    if (occ !== 3'd0 || iss_valid !== 1'b0) begin
      bad++; $display("FAIL basic_drain got occ=%0d v=%b exp occ=0 v=0",
                      occ, iss_valid);
    end
    total++;
  endtask

  task automatic test_cdb_wake();
    drive_disp(5'd6, 3'd2, 16'h0000, 16'h0007, 1'b1, 3'd1);
    iss_ready = 1'b1;
    @(negedge clk);
    if (iss_valid !== 1'b0 || occ !== 3'd1) begin
      bad++; $display("FAIL cdb_wait got v=%b occ=%0d exp v=0 occ=1",
                      iss_valid, occ);
    end
    total++;
    disp_valid = 1'b0;
    @(negedge clk);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd1;
    cdb_data  = 16'h1234;
    if (iss_valid !== 1'b0) begin
      bad++; $display("FAIL cdb_pre got v=%b exp v=0", iss_valid);
    end
    total++;
    @(negedge clk);
    if (iss_valid !== 1'b1 || iss_vj !== 16'h1234 ||
        iss_vk !== 16'h0007) begin
      bad++; $display("FAIL cdb_wake got v=%b vj=%h vk=%h exp v=1 vj=1234 vk=0007",
                      iss_valid, iss_vj, iss_vk);
    end
    total++;
    cdb_valid = 1'b0;
    @(negedge clk);
    if (occ !== 3'd0) begin
      bad++; $display("FAIL cdb_drain got occ=%0d exp=0", occ);
    end
    total++;
  endtask

  task automatic test_bypass();
    drive_disp(5'd9, 3'd6, 16'h0000, 16'h0011, 1'b1, 3'd4);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd4;
    cdb_data  = 16'hBEEF;
    iss_ready = 1'b1;
    @(negedge clk);
    if (iss_valid !== 1'b1 || iss_vj !== 16'hBEEF ||
        iss_op !== 5'd9) begin
      bad++; $display("FAIL bypass got v=%b op=%0d vj=%h exp v=1 op=9 vj=beef",
                      iss_valid, iss_op, iss_vj);
    end
    total++;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    @(negedge clk);
    if (occ !== 3'd0) begin
      bad++; $display("FAIL bypass_drain got occ=%0d exp=0", occ);
    end
    total++;
  endtask

  task automatic test_full_order();
    iss_ready = 1'b0;
    drive_disp(5'd10, 3'd1, 16'h0000, 16'h000A, 1'b1, 3'd2);
    @(negedge clk);
    drive_disp(5'd11, 3'd2, 16'h00B1, 16'h00B2, 1'b0, 3'd0);
    @(negedge clk);
    drive_disp(5'd12, 3'd3, 16'h0000, 16'h00C2, 1'b1, 3'd5);
    @(negedge clk);
    drive_disp(5'd13, 3'd4, 16'h00D1, 16'h00D2, 1'b0, 3'd0);
    @(negedge clk);
    if (occ !== 3'd4 || disp_ready !== 1'b0) begin
      bad++; $display("FAIL full_bound got occ=%0d rdy=%b exp occ=4 rdy=0",
                      occ, disp_ready);
    end
    total++;
    if (iss_valid !== 1'b1 || iss_op !== 5'd11) begin
      bad++; $display("FAIL full_selB got v=%b op=%0d exp v=1 op=11",
                      iss_valid, iss_op);
    end
    total++;
    disp_valid = 1'b0;
    cdb_valid  = 1'b1;
    cdb_tag    = 3'd5;
    cdb_data   = 16'h00C1;
    @(negedge clk);
    if (iss_op !== 5'd11 || occ !== 3'd4) begin
      bad++; $display("FAIL full_stillB got op=%0d occ=%0d exp op=11 occ=4",
                      iss_op, occ);
    end
    total++;
    cdb_valid = 1'b0;
    drive_disp(5'd15, 3'd7, 16'h00F1, 16'h00F2, 1'b0, 3'd0);
    iss_ready = 1'b1;
    #1;
    if (disp_ready !== 1'b0) begin
      bad++; $display("FAIL full_issue_rdy got=%b exp=0", disp_ready);
    end
    total++;
    @(negedge clk);
    if (occ !== 3'd3 || iss_op !== 5'd12 ||
        iss_vj !== 16'h00C1 || iss_vk !== 16'h00C2) begin
      bad++; $display("FAIL order_C got occ=%0d op=%0d vj=%h vk=%h exp occ=3 op=12 vj=00c1 vk=00c2",
                      occ, iss_op, iss_vj, iss_vk);
    end
    total++;
    drive_disp(5'd14, 3'd5, 16'h00E1, 16'h00E2, 1'b0, 3'd0);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd2;
    cdb_data  = 16'h00A1;
    @(negedge clk);
    if (occ !== 3'd3) begin
      bad++; $display("FAIL disp_and_iss_occ got=%0d exp=3", occ);
    end
    total++;
    if (iss_op !== 5'd10 || iss_vj !== 16'h00A1 ||
        iss_vk !== 16'h000A) begin
      bad++; $display("FAIL order_A got op=%0d vj=%h vk=%h exp op=10 vj=00a1 vk=000a",
                      iss_op, iss_vj, iss_vk);
    end
    total++;
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    @(negedge clk);
    if (iss_op !== 5'd13 || occ !== 3'd2) begin
      bad++; $display("FAIL order_D got op=%0d occ=%0d exp op=13 occ=2",
                      iss_op, occ);
    end
    total++;
    @(negedge clk);
    if (iss_op !== 5'd14 || iss_vj !== 16'h00E1 || occ !== 3'd1) begin
      bad++; $display("FAIL order_E got op=%0d vj=%h occ=%0d exp op=14 vj=00e1 occ=1",
                      iss_op, iss_vj, occ);
    end
    total++;
    @(negedge clk);
    if (occ !== 3'd0 || iss_valid !== 1'b0 || iss_op !== 5'd0) begin
      bad++; $display("FAIL empty got occ=%0d v=%b op=%0d exp occ=0 v=0 op=0",
                      occ, iss_valid, iss_op);
    end
    total++;
  endtask

  task automatic test_flush();
    iss_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive_disp(5'(i), 3'(i), 16'(i), 16'(i), 1'b0, 3'd0);
      @(negedge clk);
    end
    if (occ !== 3'd3) begin
      bad++; $display("FAIL flush_pre got occ=%0d exp=3", occ);
    end
    total++;
    drive_disp(5'd7, 3'd7, 16'h0077, 16'h0077, 1'b0, 3'd0);
    flush = 1'b1;
    #1;
    if (disp_ready !== 1'b0) begin
      bad++; $display("FAIL flush_rdy got=%b exp=0", disp_ready);
    end
    total++;
    @(negedge clk);
    flush      = 1'b0;
    disp_valid = 1'b0;
    if (occ !== 3'd0 || iss_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear got occ=%0d v=%b exp occ=0 v=0",
                      occ, iss_valid);
    end
    total++;
    @(negedge clk);
    if (occ !== 3'd0 || iss_op !== 5'd0) begin
      bad++; $display("FAIL flush_absent got occ=%0d op=%0d exp occ=0 op=0",
                      occ, iss_op);
    end
    total++;
  endtask

  task automatic test_async_reset();
    iss_ready = 1'b0;
    drive_disp(5'd3, 3'd1, 16'h0042, 16'h0043, 1'b0, 3'd0);
    @(negedge clk);
    disp_valid = 1'b0;
    if (iss_valid !== 1'b1 || occ !== 3'd1) begin
      bad++; $display("FAIL arst_pre got v=%b occ=%0d exp v=1 occ=1",
                      iss_valid, occ);
    end
    total++;
    #2;
    rst_n = 1'b0;
    #1;
    if (iss_valid !== 1'b0 || occ !== 3'd0) begin
      bad++; $display("FAIL arst got v=%b occ=%0d exp v=0 occ=0",
                      iss_valid, occ);
    end
    total++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wake();
    test_bypass();
    test_full_order();
    test_flush();
    test_async_reset();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
